// File: rtl/softmax_norm.sv
// softmax_norm: buffers VEC_LEN exponent results, then divides each by their sum.
// Define SOFTMAX_ROUND_EN for a round-half-up quotient (one extra divider cycle).
module softmax_norm #(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIXED_PNT  = 8,
  parameter  int VEC_LEN    = 8,
  localparam int IDX_W      = $clog2(VEC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  input  logic                  out_ready,
  output logic                  div_by_zero,
  output logic                  done
);

  localparam int SUM_W   = DATA_WIDTH + $clog2(VEC_LEN);
  localparam int DIV_CYC = DATA_WIDTH + FIXED_PNT;
`ifdef SOFTMAX_ROUND_EN
  localparam int RND     = 1;
`else
  localparam int RND     = 0;
`endif
  localparam int QW      = DIV_CYC + RND;
  localparam int CNT_W   = $clog2(QW + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(QW - 1);
  localparam logic [QW-1:0]    ONE_Q     = QW'(1) << FIXED_PNT;

  typedef enum logic [1:0] {
    COLLECT,
    DIV,
    OUT
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] ebuf [VEC_LEN];
  logic [SUM_W-1:0]      sum;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [CNT_W-1:0]      cnt;
  logic [SUM_W-1:0]      rem;
  logic [QW-2:0]         quo;

  logic [DATA_WIDTH-1:0] in_v;
  logic [QW-1:0]         dvd;
  logic                  bit_in;
  logic [SUM_W:0]        rem_sh;
  logic [SUM_W:0]        diff;
  logic                  ge;
  logic [SUM_W-1:0]      rem_nxt;
  logic [QW-1:0]         quo_nxt;
  logic [QW-1:0]         q_res;
  logic [DATA_WIDTH-1:0] res;

  // Negative exponents never occur legitimately; clamp them to zero.
  assign in_v = in_data[DATA_WIDTH-1] ? '0 : in_data;

  assign in_ready = rst_n & (state == COLLECT);

  // One restoring-division step: shift in next dividend bit, try subtract.
  always_comb begin
    dvd     = QW'(ebuf[rd_idx]) << (FIXED_PNT + RND);
    bit_in  = dvd[LAST_STEP - cnt];
    rem_sh  = {rem, bit_in};
    diff    = rem_sh - {1'b0, sum};
    ge      = rem_sh[SUM_W] | ~diff[SUM_W];
    rem_nxt = ge ? diff[SUM_W-1:0] : rem_sh[SUM_W-1:0];
    quo_nxt = {quo, ge};
  end

  // Final quotient: optional round-half-up, then saturate at 1.0.
  always_comb begin
`ifdef SOFTMAX_ROUND_EN
    q_res = (quo_nxt >> 1) + QW'(quo_nxt[0]);
`else
    q_res = quo_nxt;
`endif
    res = (q_res > ONE_Q) ? DATA_WIDTH'(ONE_Q)
                          : q_res[DATA_WIDTH-1:0];
  end

  // Control FSM plus buffer, sum and divider datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      for (int i = 0; i < VEC_LEN; i++) begin
        ebuf[i] <= '0;
      end
      sum         <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (in_valid) begin
            ebuf[wr_idx] <= in_v;
            sum          <= sum + SUM_W'(in_v);
            wr_idx       <= wr_idx + 1'b1;
            if (wr_idx == LAST_IDX) begin
              state  <= DIV;
              rd_idx <= '0;
              cnt    <= '0;
              rem    <= '0;
              quo    <= '0;
            end
          end
        end
        DIV: begin
          if (sum == '0) begin
            state       <= OUT;
            out_valid   <= 1'b1;
            out_data    <= '0;
            out_idx     <= rd_idx;
            div_by_zero <= 1'b1;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt[QW-2:0];
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              state       <= OUT;
              out_valid   <= 1'b1;
              out_data    <= res;
              out_idx     <= rd_idx;
              div_by_zero <= 1'b0;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (rd_idx == LAST_IDX) begin
              state       <= COLLECT;
              done        <= 1'b1;
              sum         <= '0;
              wr_idx      <= '0;
              div_by_zero <= 1'b0;
            end else begin
              state  <= DIV;
              rd_idx <= rd_idx + 1'b1;
              cnt    <= '0;
              rem    <= '0;
              quo    <= '0;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
